// File: rtl/decode_stage_q.sv
// decode_stage_q
//   Registered RV32 decode stage between fetch and issue. Each accepted
//   instruction is decoded combinationally and written, together with its pc,
//   into a DEPTH-entry FIFO. The head entry drives the outputs, and the payload
//   reads as all-zero while the queue is empty. A flush empties the queue.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_flush             drop all queued entries and any same-cycle push
//   in_valid/in_ready   upstream handshake (in_ready = count != DEPTH)
//   in_inst, in_pc      raw instruction and its pc
//   out_valid/out_ready downstream handshake on the head entry
//   out_pc              pc of the head entry
//   out_inst_id         one-hot instruction id: bit n set for instruction n
//                        0 LUI 1 AUIPC 2 JAL 3 JALR 4-9 BEQ,BNE,BLT,BGE,BLTU,BGEU
//                        10-14 LB,LH,LW,LBU,LHU 15-17 SB,SH,SW
//                        18-23 ADDI,SLTI,SLTIU,XORI,ORI,ANDI 24-26 SLLI,SRLI,SRAI
//                        27-36 ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND 37 FENCE
//                        38-42 ECALL,EBREAK,MRET,SRET,WFI 43-50 MUL..REMU
//                        51 FLW 52 FSW 53-58 CSRRW,CSRRS,CSRRC,CSRRWI,CSRRSI,CSRRCI
//                        63 UNKNOWN
//   out_typ             one-hot class: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SYSTEM
//   out_rd/rs1/rs2      integer register indices, 0 when unused
//   out_fp_rd/fp_rs2    FP register indices, 0 when unused
//   out_*_we/_used      register write enables and read-use flags
//   out_fun3/fun7       funct fields (fun7 only for R-type and immediate shifts)
//   out_csr             imm[11:0] for SYSTEM instructions, else 0
//   out_imm             decoded immediate (shamt for shifts, zimm for CSR*I)
//   out_illegal         instruction not recognised or extension disabled
module decode_stage_q #(
   parameter int PC_W  = 32,
   parameter int DEPTH = 2,
   parameter bit EN_M  = 1'b1,
   parameter bit EN_F  = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [63:0]     out_inst_id,
   output logic [6:0]      out_typ,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_fp_rd,
   output logic [4:0]      out_fp_rs2,
   output logic            out_rd_we,
   output logic            out_rs1_used,
   output logic            out_rs2_used,
   output logic            out_fp_we,
   output logic            out_fp_rs2_used,
   output logic [2:0]      out_fun3,
   output logic [6:0]      out_fun7,
   output logic [11:0]     out_csr,
   output logic [31:0]     out_imm,
   output logic            out_illegal
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [6:0] T_R = 7'b0000001, T_I = 7'b0000010, T_S = 7'b0000100,
                          T_B = 7'b0001000, T_U = 7'b0010000, T_J = 7'b0100000,
                          T_SYS = 7'b1000000;
   localparam logic [63:0] INST_UNKNOWN = 64'd1 << 63;

   typedef struct packed {
      logic [63:0] inst_id;
      logic [6:0]  typ;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  fp_rd;
      logic [4:0]  fp_rs2;
      logic        rd_we;
      logic        rs1_used;
      logic        rs2_used;
      logic        fp_we;
      logic        fp_rs2_used;
      logic [2:0]  fun3;
      logic [6:0]  fun7;
      logic [11:0] csr;
      logic [31:0] imm;
      logic        illegal;
   } dec_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      dec_t            dec;
   } entry_t;

   // Field extraction
   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [4:0]  rd_f, rs1_f, rs2_f;
   logic [11:0] imm12;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opc   = in_inst[6:0];
   assign rd_f  = in_inst[11:7];
   assign f3    = in_inst[14:12];
   assign rs1_f = in_inst[19:15];
   assign rs2_f = in_inst[24:20];
   assign f7    = in_inst[31:25];
   assign imm12 = in_inst[31:20];
   assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
   assign imm_u = {in_inst[31:12], 12'h000};
   assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};

   // Stage 0: combinational decode of the incoming instruction
   dec_t       dec_p0;
   logic       legal;
   logic [5:0] idx;

   always_comb begin
      dec_p0 = '0;
      legal  = 1'b0;
      idx    = 6'd63;
      case (opc)
         7'b0110111, 7'b0010111: begin
            legal      = 1'b1;
            idx        = (opc == 7'b0110111) ? 6'd0 : 6'd1;
            dec_p0.typ = T_U;
            dec_p0.rd  = rd_f;
            dec_p0.imm = imm_u;
         end
         7'b1101111: begin
            legal      = 1'b1;
            idx        = 6'd2;
            dec_p0.typ = T_J;
            dec_p0.rd  = rd_f;
            dec_p0.imm = imm_j;
         end
         7'b1100111: begin
            legal           = (f3 == 3'd0);
            idx             = 6'd3;
            dec_p0.typ      = T_I;
            dec_p0.rd       = rd_f;
            dec_p0.rs1      = rs1_f;
            dec_p0.rs1_used = 1'b1;
            dec_p0.fun3     = f3;
            dec_p0.imm      = imm_i;
         end
         7'b1100011: begin
            legal           = 1'b1;
            dec_p0.typ      = T_B;
            dec_p0.rs1      = rs1_f;
            dec_p0.rs2      = rs2_f;
            dec_p0.rs1_used = 1'b1;
            dec_p0.rs2_used = 1'b1;
            dec_p0.fun3     = f3;
            dec_p0.imm      = imm_b;
            case (f3)
               3'd0:    idx = 6'd4;
               3'd1:    idx = 6'd5;
               3'd4:    idx = 6'd6;
               3'd5:    idx = 6'd7;
               3'd6:    idx = 6'd8;
               3'd7:    idx = 6'd9;
               default: legal = 1'b0;
            endcase
         end
         7'b0000011: begin
            legal           = 1'b1;
            dec_p0.typ      = T_I;
            dec_p0.rd       = rd_f;
            dec_p0.rs1      = rs1_f;
            dec_p0.rs1_used = 1'b1;
            dec_p0.fun3     = f3;
            dec_p0.imm      = imm_i;
            case (f3)
               3'd0:    idx = 6'd10;
               3'd1:    idx = 6'd11;
               3'd2:    idx = 6'd12;
               3'd4:    idx = 6'd13;
               3'd5:    idx = 6'd14;
               default: legal = 1'b0;
            endcase
         end
         7'b0100011: begin
            legal           = (f3 <= 3'd2);
            idx             = 6'd15 + {3'b000, f3};
            dec_p0.typ      = T_S;
            dec_p0.rs1      = rs1_f;
            dec_p0.rs2      = rs2_f;
            dec_p0.rs1_used = 1'b1;
            dec_p0.rs2_used = 1'b1;
            dec_p0.fun3     = f3;
            dec_p0.imm      = imm_s;
         end
         7'b0010011: begin
            legal           = 1'b1;
            dec_p0.typ      = T_I;
            dec_p0.rd       = rd_f;
            dec_p0.rs1      = rs1_f;
            dec_p0.rs1_used = 1'b1;
            dec_p0.fun3     = f3;
            dec_p0.imm      = imm_i;
            case (f3)
               3'd0: idx = 6'd18;
               3'd2: idx = 6'd19;
               3'd3: idx = 6'd20;
               3'd4: idx = 6'd21;
               3'd6: idx = 6'd22;
               3'd7: idx = 6'd23;
               3'd1: begin
                  legal       = (f7 == 7'd0);
                  idx         = 6'd24;
                  dec_p0.imm  = {27'd0, rs2_f};
                  dec_p0.fun7 = f7;
               end
               default: begin
                  // funct3 101: funct7 selects logical vs arithmetic right shift
                  legal       = (f7 == 7'd0) || (f7 == 7'h20);
                  idx         = (f7 == 7'h20) ? 6'd26 : 6'd25;
                  dec_p0.imm  = {27'd0, rs2_f};
                  dec_p0.fun7 = f7;
               end
            endcase
         end
         7'b0110011: begin
            dec_p0.typ      = T_R;
            dec_p0.rd       = rd_f;
            dec_p0.rs1      = rs1_f;
            dec_p0.rs2      = rs2_f;
            dec_p0.rs1_used = 1'b1;
            dec_p0.rs2_used = 1'b1;
            dec_p0.fun3     = f3;
            dec_p0.fun7     = f7;
            if (f7 == 7'd0) begin
               legal = 1'b1;
               case (f3)
                  3'd0:    idx = 6'd27;
                  3'd1:    idx = 6'd29;
                  3'd2:    idx = 6'd30;
                  3'd3:    idx = 6'd31;
                  3'd4:    idx = 6'd32;
                  3'd5:    idx = 6'd33;
                  3'd6:    idx = 6'd35;
                  default: idx = 6'd36;
               endcase
            end else if (f7 == 7'h20) begin
               legal = (f3 == 3'd0) || (f3 == 3'd5);
               idx   = (f3 == 3'd0) ? 6'd28 : 6'd34;
            end else if (f7 == 7'd1) begin
               legal = EN_M;
               idx   = 6'd43 + {3'b000, f3};
            end
         end
         7'b0001111: begin
            legal       = (f3 == 3'd0);
            idx         = 6'd37;
            dec_p0.typ  = T_I;
            dec_p0.fun3 = f3;
            dec_p0.imm  = imm_i;
         end
         7'b1110011: begin
            legal       = 1'b1;
            dec_p0.typ  = T_SYS;
            dec_p0.csr  = imm12;
            dec_p0.fun3 = f3;
            case (f3)
               3'd0: begin
                  case (imm12)
                     12'h000: idx = 6'd38;
                     12'h001: idx = 6'd39;
                     12'h302: idx = 6'd40;
                     12'h102: idx = 6'd41;
                     12'h105: idx = 6'd42;
                     default: legal = 1'b0;
                  endcase
               end
               3'd1, 3'd2, 3'd3: begin
                  idx             = 6'd52 + {3'b000, f3};
                  dec_p0.rd       = rd_f;
                  dec_p0.rs1      = rs1_f;
                  dec_p0.rs1_used = 1'b1;
               end
               3'd5, 3'd6, 3'd7: begin
                  // rs1 field carries a 5-bit zero-extended immediate
                  idx        = 6'd51 + {3'b000, f3};
                  dec_p0.rd  = rd_f;
                  dec_p0.imm = {27'd0, rs1_f};
               end
               default: legal = 1'b0;
            endcase
         end
         7'b0000111: begin
            legal           = EN_F && (f3 == 3'd2);
            idx             = 6'd51;
            dec_p0.typ      = T_I;
            dec_p0.fp_rd    = rd_f;
            dec_p0.fp_we    = 1'b1;
            dec_p0.rs1      = rs1_f;
            dec_p0.rs1_used = 1'b1;
            dec_p0.fun3     = f3;
            dec_p0.imm      = imm_i;
         end
         7'b0100111: begin
            legal              = EN_F && (f3 == 3'd2);
            idx                = 6'd52;
            dec_p0.typ         = T_S;
            dec_p0.rs1         = rs1_f;
            dec_p0.rs1_used    = 1'b1;
            dec_p0.fp_rs2      = rs2_f;
            dec_p0.fp_rs2_used = 1'b1;
            dec_p0.fun3        = f3;
            dec_p0.imm         = imm_s;
         end
         default: legal = 1'b0;
      endcase

      if (legal) begin
         dec_p0.inst_id = 64'd1 << idx;
         // rd is only populated for instructions that write an integer rd
         dec_p0.rd_we   = (dec_p0.rd != 5'd0);
      end else begin
         dec_p0         = '0;
         dec_p0.inst_id = INST_UNKNOWN;
         dec_p0.illegal = 1'b1;
      end
   end

   // Stage 1: output queue
   entry_t           q_p1 [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push, pop;
   entry_t           head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~i_flush;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) q_p1[wr_ptr] <= '{pc: in_pc, dec: dec_p0};
   end

   assign head = out_valid ? q_p1[rd_ptr] : '0;

   assign out_pc          = head.pc;
   assign out_inst_id     = head.dec.inst_id;
   assign out_typ         = head.dec.typ;
   assign out_rd          = head.dec.rd;
   assign out_rs1         = head.dec.rs1;
   assign out_rs2         = head.dec.rs2;
   assign out_fp_rd       = head.dec.fp_rd;
   assign out_fp_rs2      = head.dec.fp_rs2;
   assign out_rd_we       = head.dec.rd_we;
   assign out_rs1_used    = head.dec.rs1_used;
   assign out_rs2_used    = head.dec.rs2_used;
   assign out_fp_we       = head.dec.fp_we;
   assign out_fp_rs2_used = head.dec.fp_rs2_used;
   assign out_fun3        = head.dec.fun3;
   assign out_fun7        = head.dec.fun7;
   assign out_csr         = head.dec.csr;
   assign out_imm         = head.dec.imm;
   assign out_illegal     = head.dec.illegal;

endmodule
